// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter and sequencer in front of a single-port, word-wide data memory.
// Sub-word stores become a read-modify-write pair because the memory only accepts whole words.
module data_mem_arbiter #(
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [7:0]  req_be,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // state | meaning
    // IDLE  | accepting new requests
    // RD    | read data returning from memory
    // RMW   | old word returning; merged word written this cycle
    typedef enum logic [1:0] {S_IDLE, S_RD, S_RMW} state_t;

    state_t                   state_q, state_d;
    logic                     last_q, last_d;
    logic                     id_q, id_d;
    logic [MEM_ADDR_BITS-1:0] widx_q, widx_d;
    logic [3:0]               be_q, be_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [1:0]               rsp_valid_q, rsp_valid_d;
    logic [31:0]              rsp_rdata_q, rsp_rdata_d;

    logic                     gnt_id;
    logic                     accept;
    logic                     sel_we;
    logic [3:0]               sel_be;
    logic [31:0]              sel_addr;
    logic [31:0]              sel_wdata;
    logic [MEM_ADDR_BITS-1:0] sel_widx;
    logic [31:0]              merged;
    logic                     unused_addr_bits;

    always_comb begin
        gnt_id = 1'b0;
        case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_q;
            default: gnt_id = 1'b0;
        endcase
    end

    // Gating with rst_n keeps req_ready low while reset is held.
    assign accept    = (state_q == S_IDLE) && rst_n && (|req_valid);
    assign sel_we    = req_we[gnt_id];
    assign sel_be    = gnt_id ? req_be[7:4]      : req_be[3:0];
    assign sel_addr  = gnt_id ? req_addr[63:32]  : req_addr[31:0];
    assign sel_wdata = gnt_id ? req_wdata[63:32] : req_wdata[31:0];
    assign sel_widx  = sel_addr[MEM_ADDR_BITS+1:2];

    assign unused_addr_bits = ^{sel_addr[31:MEM_ADDR_BITS+2], sel_addr[1:0]};

    always_comb begin
        merged = '0;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : mem_read_data[8*k +: 8];
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        id_d           = id_q;
        widx_d         = widx_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        rsp_valid_d    = '0;
        rsp_rdata_d    = rsp_rdata_q;
        req_ready      = '0;
        mem_write_en   = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready[gnt_id] = 1'b1;
                    last_d            = gnt_id;
                    id_d              = gnt_id;
                    if (!sel_we) begin
                        mem_addr = 32'(sel_widx);
                        state_d  = S_RD;
                    end else if (sel_be == 4'hF) begin
                        mem_write_en        = 1'b1;
                        mem_addr            = 32'(sel_widx);
                        mem_write_data      = sel_wdata;
                        rsp_valid_d[gnt_id] = 1'b1;
                        rsp_rdata_d         = '0;
                    end else if (sel_be == 4'h0) begin
                        rsp_valid_d[gnt_id] = 1'b1;
                        rsp_rdata_d         = '0;
                    end else begin
                        mem_addr = 32'(sel_widx);
                        widx_d   = sel_widx;
                        be_d     = sel_be;
                        wdata_d  = sel_wdata;
                        state_d  = S_RMW;
                    end
                end
            end
            S_RD: begin
                rsp_valid_d[id_q] = 1'b1;
                rsp_rdata_d       = mem_read_data;
                state_d           = S_IDLE;
            end
            S_RMW: begin
                mem_write_en      = 1'b1;
                mem_addr          = 32'(widx_q);
                mem_write_data    = merged;
                rsp_valid_d[id_q] = 1'b1;
                rsp_rdata_d       = '0;
                state_d           = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            widx_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            widx_q      <= widx_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-port, word-wide `DATA_MEM`. It shares the memory between requester 0, the pipeline MEM stage, and requester 1, the loader/debug port. It converts byte addresses to word indices and implements byte-enabled (sub-word) stores as read-modify-write sequences, because the memory only supports whole-word writes. It returns exactly one response per accepted request.

## Interface
- `MEM_ADDR_BITS`, default 12: word-index bits driven on `mem_addr`; `mem_addr` bits above this are 0.
- `clk`  in  1  single clock, all state on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `req_valid`  in  2  per-requester request valid, bit i = requester i.
- `req_ready`  out  2  per-requester accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_we`  in  2  1 = write, 0 = read.
- `req_be`  in  8  byte enables, `[4i+3:4i]` for requester i, lane-aligned.
- `req_addr`  in  64  byte address, `[32i+31:32i]`.
- `req_wdata`  in  64  write data, `[32i+31:32i]`, lane-aligned.
- `rsp_valid`  out  2  one-cycle response pulse to requester i.
- `rsp_rdata`  out  32  read data; 0 for write responses.
- `mem_write_en`  out  1  to `DATA_MEM.write_en`.
- `mem_addr`  out  32  word index: `{zeros, req_addr[MEM_ADDR_BITS+1:2]}`.
- `mem_write_data`  out  32  to `DATA_MEM.write_data`.
- `mem_read_data`  in  32  from `DATA_MEM.read_data`; registered and valid the cycle after the address.

## Operation
- FSM states:
  - IDLE: accepts new requests.
  - RD: read data returning from memory.
  - RMW: old word returning; merged word is written this cycle.
- `req_ready` is nonzero only in IDLE and out of reset. It is one-hot, going to the granted requester.
- Arbitration is round-robin with a 1-bit `last` pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester != `last` is granted.
  - `last` updates on accept only.
  - Reset value of `last` is 1, so requester 0 wins the first tie.
- Accepted request in IDLE, by type:
  - Read: drive `mem_addr`, `mem_write_en`=0; go to RD.
  - Write with `be`=4'hF: drive `mem_write_en`=1, `mem_addr`, `mem_write_data`=`wdata` in the same cycle; stay in IDLE.
  - Write with `be`=0: no memory access; stay in IDLE.
  - Write with partial `be`: drive a read of `mem_addr`; latch id, address, `be` and `wdata`; go to RMW.
- RD: capture `mem_read_data` into the `rsp_rdata` register; return to IDLE.
- RMW: drive `mem_write_en`=1 with the latched address and the merged word, then return to IDLE.
  - Merged byte k = `be[k]` ? `wdata[8k+7:8k]` : `mem_read_data[8k+7:8k]`.
- Responses are registered pulses, one per accepted request, on `rsp_valid[id]` only.
- `mem_*` outputs are combinational from state and the granted request. When not writing, `mem_write_data` = 0. In IDLE with no accept, `mem_addr` = 0.
- `req_addr[1:0]` is ignored. Addresses alias every 2^(`MEM_ADDR_BITS`+2) bytes.
- Requesters hold `req_*` stable while valid and not ready. The arbiter does not check this.

## Timing
- Accept occurs in cycle T.
  - Full write: memory written at the T edge; `rsp_valid` high in T+1.
  - `be`=0 write: `rsp_valid` high in T+1.
  - Read: `rsp_valid` high in T+2 with data.
  - Partial write: memory written at the T+1 edge; `rsp_valid` high in T+2.
- Throughput:
  - Back-to-back full writes: one per cycle.
  - Reads and partial writes: one per 2 cycles, because RD/RMW block accept.
- A read accepted at T+1 after a full write to the same word at T returns the new data.
- A request accepted right after RMW sees the merged word.
- Reset values: state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `mem_write_en`=0, `mem_addr`=0, `mem_write_data`=0, `last`=1.
- Reset asserted mid-RD/RMW takes effect immediately:
  - `mem_write_en` drops at once.
  - An in-flight RMW write is not performed.
  - No response is issued; the pending request is lost.

## Test plan
- Reset, then req0 full write addr 0x10, data 0xDEADBEEF at T: `mem_write_en`=1, `mem_addr`=4 at T; `rsp_valid`=2'b01 at T+1. Then req0 read 0x10: `rsp_rdata`=0xDEADBEEF two cycles after accept.
- Both valid every cycle, reads: grants alternate 0,1,0,1 starting with 0; each `rsp_valid` bit pulses once per grant; `req_ready` is 0 in RD cycles.
- Word 0x20 = 0x11223344; req1 write `be`=4'b0010, data 0x0000AA00: memory becomes 0x1122AA44; `mem_write_en` high only in the RMW cycle; `rsp_valid`=2'b10 at T+2; a later read returns 0x1122AA44.
- Write with `be`=0 to a word holding 0x55: no `mem_write_en` pulse; response at T+1; the word is still 0x55.
- Assert `rst_n`=0 during the RMW cycle: `mem_write_en`=0 immediately; the word is unchanged; there is no `rsp_valid`; after release the first tie grants requester 0.
- Address aliasing: write 0x4004, then read 0x0004 (`MEM_ADDR_BITS`=12): `mem_addr`=1 both times; the read returns the written data.
